// File: rtl/irq_pkg.sv
// irq_pkg: shared types and constants for the interrupt conditioner.
// Channel indices map the raw sources onto CPU int1..int4.
package irq_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PULSE = 2'd1,
        GAP   = 2'd2
    } irq_state_e;

    localparam int IRQ_NINT1 = 0;
    localparam int IRQ_NINT2 = 1;
    localparam int IRQ_NINT3 = 2;
    localparam int IRQ_FRAME = 3;

endpackage

// File: rtl/irq_channel.sv
// irq_channel: one interrupt source path -- sync, debounce, rising-edge
// detect, fixed-width pulse FSM with one-deep pending and sticky overflow.
module irq_channel
    import irq_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEBOUNCE    = 4,
    parameter bit BYPASS      = 1'b0,
    parameter bit INVERT      = 1'b0,
    parameter int PULSE_LEN   = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic raw_i,
    input  logic en_i,
    input  logic ovf_clr_i,
    output logic int_o,
    output logic ovf_o
);

    localparam int CW = $clog2(DEBOUNCE) + 1;
    localparam int PW = $clog2(PULSE_LEN) + 1;
    localparam logic [CW-1:0] CNT_MAX   = CW'(DEBOUNCE - 1);
    localparam logic [PW-1:0] PCNT_INIT = PW'(PULSE_LEN - 1);

    logic                   act;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   stable_q;
    logic                   stable_d;
    logic [CW-1:0]          cnt_q;
    logic [CW-1:0]          cnt_d;
    logic                   rise_c;
    logic                   rise_q;
    logic                   ev;
    irq_state_e             state_q;
    logic [PW-1:0]          pcnt_q;
    logic                   pend_q;
    logic                   ovf_q;
    logic                   int_q;

    assign act  = raw_i ^ INVERT;
    assign sync = sync_q[SYNC_STAGES-1];

    // Metastability chain; cleared to the inactive level on reset.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], act};
        end
    end

    // Accept a new level only after it has differed for DEBOUNCE cycles.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (BYPASS) begin
            stable_d = sync;
        end else if (sync != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    assign rise_c = stable_d & ~stable_q;

    // Debounced level and its edge; the debounced edge is retimed one cycle.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_c;
        end
    end

    // Bypassed channels take the synced edge directly.
    assign ev = (BYPASS ? rise_c : rise_q) & en_i;

    // Pulse FSM with one-deep pending queue; overflow set beats clear.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            pcnt_q  <= '0;
            pend_q  <= 1'b0;
            ovf_q   <= 1'b0;
            int_q   <= 1'b0;
        end else begin
            int_q <= (state_q == PULSE);
            if (ovf_clr_i) begin
                ovf_q <= 1'b0;
            end
            unique case (state_q)
                IDLE: begin
                    if (ev) begin
                        state_q <= PULSE;
                        pcnt_q  <= PCNT_INIT;
                    end
                end
                PULSE: begin
                    if (ev) begin
                        if (pend_q) begin
                            ovf_q <= 1'b1;
                        end else begin
                            pend_q <= 1'b1;
                        end
                    end
                    if (pcnt_q == '0) begin
                        state_q <= (pend_q || ev) ? GAP : IDLE;
                    end else begin
                        pcnt_q <= pcnt_q - 1'b1;
                    end
                end
                GAP: begin
                    pend_q  <= ev;
                    state_q <= PULSE;
                    pcnt_q  <= PCNT_INIT;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign int_o = int_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/irq_conditioner.sv
// irq_conditioner: conditions nint1..nint3 and frameDrawn into clean
// active-high pulses for CPU int1..int4, with per-channel overflow flags.
module irq_conditioner
    import irq_pkg::*;
#(
    parameter int                 NUM_IRQ     = 4,
    parameter int                 SYNC_STAGES = 2,
    parameter int                 DEBOUNCE    = 4,
    parameter logic [NUM_IRQ-1:0] DEB_BYPASS  = 4'b1000,
    parameter logic [NUM_IRQ-1:0] INVERT      = 4'b0111,
    parameter int                 PULSE_LEN   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq_raw,
    input  logic [NUM_IRQ-1:0] irq_en,
    input  logic [NUM_IRQ-1:0] overflow_clr,
    output logic [NUM_IRQ-1:0] int_out,
    output logic [NUM_IRQ-1:0] overflow
);

    for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ch
        irq_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEBOUNCE    (DEBOUNCE),
            .BYPASS      (DEB_BYPASS[gi]),
            .INVERT      (INVERT[gi]),
            .PULSE_LEN   (PULSE_LEN)
        ) u_ch (
            .clk_i     (clk),
            .reset_i   (reset),
            .raw_i     (irq_raw[gi]),
            .en_i      (irq_en[gi]),
            .ovf_clr_i (overflow_clr[gi]),
            .int_o     (int_out[gi]),
            .ovf_o     (overflow[gi])
        );
    end

endmodule

// File: tb/tb_irq_conditioner.sv
// tb_irq_conditioner: directed tests for irq_conditioner.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_irq_conditioner;

    logic       clk;
    logic       reset;
    logic [3:0] irq_raw;
    logic [3:0] irq_en;
    logic [3:0] overflow_clr;
    logic [3:0] int_out;
    logic [3:0] overflow;

    int tests_run;
    int tests_failed;

    irq_conditioner dut (
        .clk          (clk),
        .reset        (reset),
        .irq_raw      (irq_raw),
        .irq_en       (irq_en),
        .overflow_clr (overflow_clr),
        .int_out      (int_out),
        .overflow     (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        tests_run++;
        if (int_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_int_out: got %b want 0000", int_out);
        end
        tests_run++;
        if (overflow !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_overflow: got %b want 0000", overflow);
        end
        reset = 1'b0;
        idle(4);
    endtask

    task automatic test_clean_edge;
        logic exp;
        irq_raw[0] = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            exp = (k == 7 || k == 8);
            tests_run++;
            if (int_out[0] !== exp) begin
                tests_failed++;
                $display("FAIL clean_edge k=%0d: int_out[0]=%b want %b",
                         k, int_out[0], exp);
            end
        end
        tests_run++;
        if (overflow !== 4'b0000) begin
            tests_failed++;
            $display("FAIL clean_overflow: got %b want 0000", overflow);
        end
        irq_raw[0] = 1'b1;
        idle(12);
    endtask

    task automatic test_glitch;
        int hi;
        hi = 0;
        irq_raw[1] = 1'b0;
        repeat (3) begin @(negedge clk); if (int_out[1]) hi++; end
        irq_raw[1] = 1'b1;
        @(negedge clk); if (int_out[1]) hi++;
        irq_raw[1] = 1'b0;
        repeat (3) begin @(negedge clk); if (int_out[1]) hi++; end
        irq_raw[1] = 1'b1;
        repeat (15) begin @(negedge clk); if (int_out[1]) hi++; end
        tests_run++;
        if (hi != 0) begin
            tests_failed++;
            $display("FAIL glitch: int_out[1] high %0d cycles want 0", hi);
        end
    endtask

    task automatic test_two_events;
        logic [11:0] got;
        for (int j = 0; j < 12; j++) begin
            irq_raw[3] = (j == 0 || j == 2);
            @(negedge clk);
            got[j] = int_out[3];
        end
        tests_run++;
        if (got !== 12'h0D8) begin
            tests_failed++;
            $display("FAIL two_events: trace %h want 0d8", got);
        end
        tests_run++;
        if (overflow[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL two_events_ovf: got %b want 0", overflow[3]);
        end
        idle(4);
    endtask

    task automatic burst(input bit with_clr, output logic [23:0] got);
        for (int j = 0; j < 24; j++) begin
            irq_raw[3]      = (j < 10) && (j % 2 == 0);
            overflow_clr[3] = with_clr && (j == 10);
            @(negedge clk);
            got[j] = int_out[3];
        end
        overflow_clr[3] = 1'b0;
    endtask

    task automatic test_overflow;
        logic [23:0] got;
        burst(1'b0, got);
        tests_run++;
        if (got !== 24'h0036D8) begin
            tests_failed++;
            $display("FAIL ovf_pulses: trace %h want 0036d8", got);
        end
        tests_run++;
        if (overflow !== 4'b1000) begin
            tests_failed++;
            $display("FAIL ovf_set: got %b want 1000", overflow);
        end
        overflow_clr[3] = 1'b1;
        @(negedge clk);
        overflow_clr[3] = 1'b0;
        tests_run++;
        if (overflow[3] !== 1'b0) begin
            tests_failed++;
            $display("FAIL ovf_clear: got %b want 0", overflow[3]);
        end
        burst(1'b1, got);
        tests_run++;
        if (overflow[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL ovf_set_beats_clr: got %b want 1", overflow[3]);
        end
    endtask

    task automatic test_enable;
        int hi;
        hi = 0;
        irq_en[2]  = 1'b0;
        irq_raw[2] = 1'b0;
        repeat (15) begin @(negedge clk); if (int_out[2]) hi++; end
        tests_run++;
        if (hi != 0) begin
            tests_failed++;
            $display("FAIL en_off: int_out[2] high %0d cycles want 0", hi);
        end
        irq_en[2] = 1'b1;
        hi = 0;
        repeat (15) begin @(negedge clk); if (int_out[2]) hi++; end
        tests_run++;
        if (hi != 0) begin
            tests_failed++;
            $display("FAIL en_reenable: int_out[2] high %0d want 0", hi);
        end
        tests_run++;
        if (overflow[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_ovf: got %b want 0", overflow[2]);
        end
        irq_raw[2] = 1'b1;
        idle(12);
    endtask

    task automatic test_simultaneous;
        irq_raw[1:0] = 2'b00;
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            if (k == 7) begin
                tests_run++;
                if (int_out !== 4'b0011) begin
                    tests_failed++;
                    $display("FAIL simul_high: got %b want 0011", int_out);
                end
            end
            if (k == 9) begin
                tests_run++;
                if (int_out !== 4'b0000) begin
                    tests_failed++;
                    $display("FAIL simul_low: got %b want 0000", int_out);
                end
            end
        end
        irq_raw[1:0] = 2'b11;
        idle(12);
    endtask

    task automatic test_reset_mid_pulse;
        bit   seen;
        logic exp;
        seen = 1'b0;
        irq_raw[0] = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            if (int_out[0]) seen = 1'b1;
        end
        tests_run++;
        if (!seen) begin
            tests_failed++;
            $display("FAIL mid_pulse_start: int_out[0]=%b want 1", int_out[0]);
        end
        reset = 1'b1;
        @(negedge clk);
        tests_run++;
        if (int_out !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset_int: got %b want 0000", int_out);
        end
        tests_run++;
        if (overflow !== 4'b0000) begin
            tests_failed++;
            $display("FAIL mid_reset_ovf: got %b want 0000", overflow);
        end
        idle(2);
        reset = 1'b0;
        for (int k = 0; k <= 14; k++) begin
            @(negedge clk);
            exp = (k == 7 || k == 8);
            tests_run++;
            if (int_out[0] !== exp) begin
                tests_failed++;
                $display("FAIL post_reset k=%0d: int_out[0]=%b want %b",
                         k, int_out[0], exp);
            end
        end
        irq_raw[0] = 1'b1;
        idle(12);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset        = 1'b1;
        irq_raw      = 4'b0111;
        irq_en       = 4'hF;
        overflow_clr = 4'h0;
        test_reset;
        test_clean_edge;
        test_glitch;
        test_two_events;
        test_overflow;
        test_enable;
        test_simultaneous;
        test_reset_mid_pulse;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
